// File: rtl/bypass_pkg.sv
// bypass_pkg: shared scoreboard entry type and default parameters for the
// operand bypass network. Entry fields are sized for the largest supported
// configuration (AREG_W <= 8, NSTAGE <= 16); narrower configs zero-extend.
package bypass_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREAD  = 2;
  localparam int DEF_NSTAGE = 3;
  localparam int DEF_AREG_W = 5;

  localparam int AREG_MAX = 8;
  localparam int RDY_MAX  = 4;

  // One in-flight producer: its destination and the first stage index at
  // which its result appears on that stage's data bus.
  typedef struct packed {
    logic                valid;
    logic [AREG_MAX-1:0] waddr;
    logic [RDY_MAX-1:0]  rdy;
  } entry_t;

endpackage

// File: rtl/bypass_match.sv
// bypass_match: per-read-port youngest-producer match, operand select and
// not-ready flag. The optional hold entry is matched at lowest priority.
module bypass_match
  import bypass_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NSTAGE = DEF_NSTAGE,
  parameter int AREG_W = DEF_AREG_W
) (
  input  entry_t [NSTAGE-1:0]        entries,
  input  logic   [NSTAGE*DATA_W-1:0] stage_data,
  input  logic   [AREG_W-1:0]        rd_addr,
  input  logic   [DATA_W-1:0]        rf_data,
  input  logic                       hold_valid,
  input  logic   [AREG_MAX-1:0]      hold_waddr,
  input  logic   [DATA_W-1:0]        hold_data,
  output logic   [DATA_W-1:0]        fwd_data,
  output logic                       not_ready
);

  logic [AREG_MAX-1:0] addr_ext;
  logic                addr_nz;

  assign addr_ext = AREG_MAX'(rd_addr);
  assign addr_nz  = |rd_addr;

  // Scan oldest to youngest so the youngest match wins, then pick the operand.
  always_comb begin
    logic               hit;
    int                 sel_idx;
    logic [RDY_MAX-1:0] sel_rdy;
    logic [DATA_W-1:0]  sel_data;
    // NOTE: every variable gets a default before any branch, so no path
    // through this block leaves a value held over and no latch is inferred.
    hit       = 1'b0;
    sel_idx   = 0;
    sel_rdy   = '0;
    sel_data  = '0;
    fwd_data  = rf_data;
    not_ready = 1'b0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (entries[i].valid && (entries[i].waddr == addr_ext)) begin
        hit      = 1'b1;
        sel_idx  = i;
        sel_rdy  = entries[i].rdy;
        sel_data = stage_data[i*DATA_W +: DATA_W];
      end
    end
    if (hit && addr_nz) begin
      // A younger unready producer blocks any older ready one.
      if (sel_idx >= int'(sel_rdy)) fwd_data  = sel_data;
      else                          not_ready = 1'b1;
    end else if (hold_valid && addr_nz && (hold_waddr == addr_ext)) begin
      fwd_data = hold_data;
    end
  end

endmodule

// File: rtl/bypass_net.sv
// bypass_net: tracks in-flight GPR writers per pipeline stage, resolves each
// read port to a forwarded result or register-file data, and raises stall on
// a load-use style hazard.
// Optional feature macro BYPASS_WB_HOLD_EN: keeps the entry retiring from the
// last stage for one more cycle, for a register file without write-through.
module bypass_net
  import bypass_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREAD  = DEF_NREAD,
  parameter int NSTAGE = DEF_NSTAGE,
  parameter int AREG_W = DEF_AREG_W
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       issue_valid,
  input  logic                       issue_wen,
  input  logic [AREG_W-1:0]          issue_waddr,
  input  logic [$clog2(NSTAGE)-1:0]  issue_rdy,
  input  logic                       advance,
  input  logic                       flush,
  input  logic [NSTAGE*DATA_W-1:0]   stage_data,
  input  logic [NREAD-1:0]           rd_en,
  input  logic [NREAD*AREG_W-1:0]    rd_addr,
  input  logic [NREAD*DATA_W-1:0]    rf_data,
  output logic [NREAD*DATA_W-1:0]    fwd_data,
  output logic                       stall
);

  entry_t [NSTAGE-1:0] entries;
  entry_t              issue_entry;
  logic   [NREAD-1:0]  not_ready;
  logic                hold_valid;
  logic [AREG_MAX-1:0] hold_waddr;
  logic [DATA_W-1:0]   hold_data;

  // Stall only matters for a real issue reading an unready operand.
  assign stall = issue_valid & |(rd_en & not_ready);

  // Entry loaded into stage 0; non-writers and r0 writers are recorded invalid.
  always_comb begin
    issue_entry.valid = issue_valid & ~stall & issue_wen & (|issue_waddr);
    issue_entry.waddr = AREG_MAX'(issue_waddr);
    issue_entry.rdy   = RDY_MAX'(issue_rdy);
  end

  // Stage tracker: flush beats advance; with neither, entries hold.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: the tracker is a handful of flops, not a RAM, so resetting every
    // field is cheap and keeps stall/fwd_data clean straight out of reset.
    if (!resetn) begin
      entries <= '0;
    end else if (flush) begin
      for (int i = 0; i < NSTAGE; i++) entries[i].valid <= 1'b0;
    end else if (advance) begin
      // NOTE: non-blocking assignments make every stage read the pre-edge
      // value of its neighbour, so the shift order in this loop is irrelevant.
      entries[0] <= issue_entry;
      for (int i = 1; i < NSTAGE; i++) entries[i] <= entries[i-1];
    end
  end

`ifdef BYPASS_WB_HOLD_EN
  // Retire hold: valid only for the cycle after an entry leaves the last stage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_valid <= 1'b0;
      hold_waddr <= '0;
      hold_data  <= '0;
    end else if (advance && !flush) begin
      hold_valid <= entries[NSTAGE-1].valid;
      hold_waddr <= entries[NSTAGE-1].waddr;
      hold_data  <= stage_data[(NSTAGE-1)*DATA_W +: DATA_W];
    end else begin
      hold_valid <= 1'b0;
    end
  end
`else
  assign hold_valid = 1'b0;
  assign hold_waddr = '0;
  assign hold_data  = '0;
`endif

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    bypass_match #(
      .DATA_W (DATA_W),
      .NSTAGE (NSTAGE),
      .AREG_W (AREG_W)
    ) u_match (
      .entries    (entries),
      .stage_data (stage_data),
      .rd_addr    (rd_addr[p*AREG_W +: AREG_W]),
      .rf_data    (rf_data[p*DATA_W +: DATA_W]),
      .hold_valid (hold_valid),
      .hold_waddr (hold_waddr),
      .hold_data  (hold_data),
      .fwd_data   (fwd_data[p*DATA_W +: DATA_W]),
      .not_ready  (not_ready[p])
    );
  end

endmodule

// File: tb/tb_bypass_net.sv
// tb_bypass_net: directed scoreboard bench for bypass_net (default build).
// Each cycle drives issue/read stimulus, queues the expected stall and
// operands, and compares them on the falling edge.
module tb_bypass_net;

  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NS = 3;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              resetn;
  logic              issue_valid;
  logic              issue_wen;
  logic [AW-1:0]     issue_waddr;
  logic [1:0]        issue_rdy;
  logic              advance;
  logic              flush;
  logic [NS*DW-1:0]  stage_data;
  logic [NR-1:0]     rd_en;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rf_data;
  logic [NR*DW-1:0]  fwd_data;
  logic              stall;

  logic [DW-1:0]     sd0, sd1, sd2;
  logic [AW-1:0]     ra0, ra1;

  typedef struct {
    string       tag;
    logic        st;
    bit          c0;
    logic [31:0] f0;
    bit          c1;
    logic [31:0] f1;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bypass_net #(
    .DATA_W (DW),
    .NREAD  (NR),
    .NSTAGE (NS),
    .AREG_W (AW)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .issue_valid (issue_valid),
    .issue_wen   (issue_wen),
    .issue_waddr (issue_waddr),
    .issue_rdy   (issue_rdy),
    .advance     (advance),
    .flush       (flush),
    .stage_data  (stage_data),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rf_data     (rf_data),
    .fwd_data    (fwd_data),
    .stall       (stall)
  );

  // Register-file read data is a fixed function of port and address.
  function automatic logic [31:0] rf_val(int p, logic [AW-1:0] a);
    return (p == 0 ? 32'hA0A0_0000 : 32'hB0B0_0000) | 32'(a);
  endfunction

  always_comb begin
    stage_data = {sd2, sd1, sd0};
    rd_addr    = {ra1, ra0};
    rf_data    = {rf_val(1, ra1), rf_val(0, ra0)};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic set_sd(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    sd0 = a;
    sd1 = b;
    sd2 = c;
  endtask

  task automatic drive(input logic iv, input logic wen, input logic [AW-1:0] wa,
                       input logic [1:0] rdy, input logic adv, input logic fl,
                       input logic [1:0] re, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    issue_valid = iv;
    issue_wen   = wen;
    issue_waddr = wa;
    issue_rdy   = rdy;
    advance     = adv;
    flush       = fl;
    rd_en       = re;
    ra0         = a0;
    ra1         = a1;
  endtask

  // Queue the expectation for this cycle, compare on the falling edge, then
  // move to just after the next rising edge ready for new stimulus.
  task automatic expect_out(input string tag, input logic st,
                            input bit c0, input logic [31:0] f0,
                            input bit c1, input logic [31:0] f1);
    exp_t e;
    sb.push_back('{tag, st, c0, f0, c1, f1});
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_stall"}, 32'(stall), 32'(e.st));
      if (e.c0) check({e.tag, "_fwd0"}, fwd_data[0*DW +: DW], e.f0);
      if (e.c1) check({e.tag, "_fwd1"}, fwd_data[1*DW +: DW], e.f1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    set_sd(32'h0, 32'h0, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state: no forwarding, no stall even with a hazard-like request.
    drive(1, 1, 8, 0, 1, 0, 2'b01, 8, 9);
    expect_out("rst", 0, 1, rf_val(0, 8), 1, rf_val(1, 9));
    resetn = 1'b1;

    // ALU write to r8, consumer reads it from stage 0, then stages 1 and 2.
    drive(1, 1, 8, 0, 1, 0, 2'b00, 1, 2);
    expect_out("alu_issue", 0, 1, rf_val(0, 1), 1, rf_val(1, 2));
    set_sd(32'h11, 32'h2222, 32'h3333);
    drive(1, 0, 0, 0, 1, 0, 2'b11, 8, 3);
    expect_out("alu_use", 0, 1, 32'h11, 1, rf_val(1, 3));
    set_sd(32'h44, 32'h22, 32'h33);
    drive(0, 0, 0, 0, 1, 0, 2'b00, 0, 8);
    expect_out("mem1_fwd", 0, 1, rf_val(0, 0), 1, 32'h22);
    set_sd(32'h44, 32'h55, 32'h88);
    drive(0, 0, 0, 0, 1, 0, 2'b00, 8, 8);
    expect_out("mem2_fwd", 0, 1, 32'h88, 1, 32'h88);
    expect_out("retired", 0, 1, rf_val(0, 8), 1, rf_val(1, 8));

    // Load to r9 followed by a use: two stall cycles, then stage-2 data.
    drive(1, 1, 9, 2, 1, 0, 2'b00, 9, 1);
    expect_out("load_issue", 0, 1, rf_val(0, 9), 1, rf_val(1, 1));
    set_sd(32'h91, 32'h92, 32'h93);
    drive(1, 0, 0, 0, 1, 0, 2'b01, 9, 5);
    expect_out("load_use1", 1, 0, 32'h0, 1, rf_val(1, 5));
    expect_out("load_use2", 1, 0, 32'h0, 1, rf_val(1, 5));
    set_sd(32'h91, 32'h92, 32'h99);
    expect_out("load_use_rel", 0, 1, 32'h99, 1, rf_val(1, 5));

    // Two writers of r4: the younger (stage 0) wins.
    drive(1, 1, 4, 0, 1, 0, 2'b00, 1, 2);
    expect_out("r4_a", 0, 1, rf_val(0, 1), 1, rf_val(1, 2));
    expect_out("r4_b", 0, 1, rf_val(0, 1), 1, rf_val(1, 2));
    set_sd(32'hB, 32'hA, 32'h33);
    drive(1, 0, 0, 0, 1, 0, 2'b11, 4, 4);
    expect_out("r4_young", 0, 1, 32'hB, 1, 32'hB);

    // Older ready ALU r6 behind a younger unready load r6: still stalls.
    drive(1, 1, 6, 0, 1, 0, 2'b00, 1, 2);
    expect_out("r6_alu", 0, 1, rf_val(0, 1), 1, rf_val(1, 2));
    drive(1, 1, 6, 2, 1, 0, 2'b00, 1, 2);
    expect_out("r6_load", 0, 1, rf_val(0, 1), 1, rf_val(1, 2));
    set_sd(32'h60, 32'h66, 32'h33);
    drive(1, 0, 0, 0, 1, 1, 2'b10, 2, 6);
    expect_out("young_unready", 1, 1, rf_val(0, 2), 0, 32'h0);
    // The flush in that stalled cycle kills everything in flight.
    drive(1, 0, 0, 0, 1, 0, 2'b11, 6, 6);
    expect_out("post_flush", 0, 1, rf_val(0, 6), 1, rf_val(1, 6));

    // Writes to r0 and non-writing instructions are never forwarded.
    drive(1, 1, 0, 0, 1, 0, 2'b00, 0, 0);
    expect_out("r0_wr", 0, 1, rf_val(0, 0), 1, rf_val(1, 0));
    set_sd(32'h77, 32'h78, 32'h79);
    drive(1, 0, 7, 0, 1, 0, 2'b11, 0, 0);
    expect_out("r0_rd", 0, 1, rf_val(0, 0), 1, rf_val(1, 0));
    set_sd(32'h70, 32'h71, 32'h72);
    drive(0, 0, 0, 0, 1, 0, 2'b11, 7, 7);
    expect_out("no_wen", 0, 1, rf_val(0, 7), 1, rf_val(1, 7));

    // Pending load with advance held low for three cycles: entries frozen.
    drive(1, 1, 10, 2, 1, 0, 2'b00, 1, 2);
    expect_out("ld10", 0, 1, rf_val(0, 1), 1, rf_val(1, 2));
    drive(1, 0, 0, 0, 0, 0, 2'b01, 10, 3);
    for (int k = 0; k < 3; k++) begin
      expect_out($sformatf("frz%0d", k), 1, 0, 32'h0, 1, rf_val(1, 3));
    end
    advance = 1'b1;
    expect_out("frz_adv1", 1, 0, 32'h0, 1, rf_val(1, 3));
    expect_out("frz_adv2", 1, 0, 32'h0, 1, rf_val(1, 3));
    set_sd(32'h1, 32'h2, 32'hAA);
    expect_out("frz_rel", 0, 1, 32'hAA, 1, rf_val(1, 3));

    // Reset asserted in the middle of a stall drops it immediately.
    drive(1, 1, 11, 2, 1, 0, 2'b00, 1, 2);
    expect_out("ld11", 0, 1, rf_val(0, 1), 1, rf_val(1, 2));
    drive(1, 0, 0, 0, 1, 0, 2'b01, 11, 3);
    expect_out("rst_pre", 1, 0, 32'h0, 1, rf_val(1, 3));
    resetn = 1'b0;
    expect_out("rst_mid", 0, 1, rf_val(0, 11), 1, rf_val(1, 3));
    resetn = 1'b1;
    expect_out("rst_after", 0, 1, rf_val(0, 11), 1, rf_val(1, 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bypass_net.md
BYPASS_NET -- requirements
Module: bypass_net

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the forwarded data.
REQ-002 SHALL have parameter NREAD, default 2: number of register read ports.
REQ-003 SHALL have parameter NSTAGE, default 3: number of tracked in-flight stages (0=EX, 1=MEM1, 2=MEM2).
REQ-004 SHALL have parameter AREG_W, default 5: width of a register address.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port issue_valid, input, 1: an instruction is presented for issue into stage 0.
REQ-008 SHALL have port issue_wen, input, 1: the issuing instruction writes a GPR.
REQ-009 SHALL have port issue_waddr, input, AREG_W: destination register of the issuing instruction.
REQ-010 SHALL have port issue_rdy, input, $clog2(NSTAGE): first stage index at which the result is valid (ALU=0, MUL=1, load=2).
REQ-011 SHALL have port advance, input, 1: the pipeline moves forward this cycle.
REQ-012 SHALL have port flush, input, 1: kill all in-flight entries.
REQ-013 SHALL have port stage_data, input, NSTAGE*DATA_W: result bus of each stage.
REQ-014 SHALL have port rd_en, input, NREAD: read port p is used by the issuing instruction.
REQ-015 SHALL have port rd_addr, input, NREAD*AREG_W: read addresses.
REQ-016 SHALL have port rf_data, input, NREAD*DATA_W: register-file read data.
REQ-017 SHALL have port fwd_data, output, NREAD*DATA_W: resolved operand for each port.
REQ-018 SHALL have port stall, output, 1: the issuing instruction must be held.

Function
REQ-019 SHALL hold NSTAGE entries {valid, waddr, rdy}; entry i describes the instruction whose result is on stage_data[i].
REQ-020 SHALL, on an edge with advance=1, shift entry i to i+1, retire entry NSTAGE-1, and load entry 0 from issue when issue_valid & ~stall, else load a bubble (valid=0).
REQ-021 SHALL hold all entries unchanged on an edge with advance=0 and flush=0.
REQ-022 SHALL clear every valid bit on an edge with flush=1; flush SHALL take priority over advance and issue.
REQ-023 SHALL record valid=0 for an issued instruction with issue_wen=0 or issue_waddr=0.
REQ-024 SHALL, per port p, select the lowest-index (youngest) valid entry whose waddr equals rd_addr[p]; address 0 SHALL never match.
REQ-025 SHALL drive fwd_data[p]=stage_data[i] when that matching entry i has i>=rdy; fwd_data[p]=rf_data[p] when no entry matches.
REQ-026 SHALL assert stall combinationally when issue_valid=1 and any port with rd_en=1 matches an entry with i<rdy; an older ready match SHALL NOT override a younger unready one.
REQ-027 SHALL have zero-cycle latency from rd_addr/stage_data to fwd_data and stall (combinational path).

Reset
REQ-028 SHALL clear all valid bits, waddr and rdy asynchronously while resetn=0, giving stall=0 and fwd_data=rf_data.
REQ-029 SHALL resume tracking on the first rising edge after resetn deasserts; reset mid-stall SHALL drop the stall.

Configuration
REQ-030 SHALL, with macro BYPASS_WB_HOLD_EN defined, keep one extra retire entry capturing the entry and stage_data leaving stage NSTAGE-1, matched at lowest priority for one cycle, covering a register file without write-through.
REQ-031 SHALL, without BYPASS_WB_HOLD_EN, keep no retire entry; the register file is required to be write-through.

Structure
REQ-032 SHALL place the entry typedef and default parameter constants in package bypass_pkg.
REQ-033 SHALL instantiate NREAD copies of sub-module bypass_match (priority match, data select, not-ready flag per port).

Verification
REQ-034 SHALL cover: ALU writes r8=0x11, next instruction reads r8 -> fwd_data[0]=0x11 from stage 0, stall=0.
REQ-035 SHALL cover: load to r9, next instruction reads r9 -> stall=1 for 2 cycles, then fwd_data=stage_data[2], stall=0.
REQ-036 SHALL cover: two in-flight writes to r4 (0xA at stage 1, 0xB at stage 0), read r4 -> 0xB selected.
REQ-037 SHALL cover: write to r0 then read r0 -> fwd_data=rf_data, stall=0.
REQ-038 SHALL cover: flush during a load-use stall -> stall=0 on the next cycle, reads return rf_data.
REQ-039 SHALL cover: advance=0 for 3 cycles with a pending load -> entries frozen, stall persists, fwd_data unchanged.
